pkt_deq_drain: RTL

Dequeue-side drain engine for the packet priority comparator. It pops head packets (data plus 6-bit priority) from the comparator's dequeue port, subject to a token-bucket rate limiter and local buffer space. It buffers them in a small FIFO and presents them downstream on a valid/ready stream. It sits between the comparator's `out_*` interface and the egress logic, and exports drain status and statistics.

---
 rtl/pkt_deq_drain_pkg.sv | 14 +
 rtl/pkt_sync_fifo.sv | 49 ++++
 rtl/pkt_deq_drain.sv | 103 ++++++++++
 3 files changed

// File: rtl/pkt_deq_drain_pkg.sv
// Shared definitions for the packet comparator slice: the priority width and
// the drain engine status encoding.
package pkt_h;

    localparam int PRIOR_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        THROTTLE,
        BACKPRESSURE
    } drain_state_e;

endpackage

// File: rtl/pkt_sync_fifo.sv
// Synchronous FIFO with first-word fall-through output read straight from the
// register array; wrap-bit pointers distinguish full from empty.
module pkt_sync_fifo #(
    parameter int WIDTH = 38,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign empty = (wptr == rptr);

    // A full FIFO refuses writes even when a read frees a slot this cycle.
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr) wptr <= wptr + 1'b1;
            if (do_rd) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr[AW-1:0]] <= wr_data;
    end

    // The head is forced to zero while empty so stale entries never show.
    assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

endmodule

// File: rtl/pkt_deq_drain.sv
// Drain engine: pops comparator head packets under a token-bucket limit into
// a local FIFO and streams them downstream; exports status and statistics.
module pkt_deq_drain
    import pkt_h::*;
#(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 8,
    parameter int BURST  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               q_valid,
    input  logic [DWIDTH-1:0]  q_data,
    input  logic [PRIOR_W-1:0] q_prior,
    output logic               q_deque_en,
    input  logic               cfg_en,
    input  logic [7:0]         cfg_rate,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DWIDTH-1:0]  m_data,
    output logic [PRIOR_W-1:0] m_prior,
    output logic [1:0]         state,
    output logic [31:0]        stat_pkts,
    output logic [PRIOR_W-1:0] stat_max_prior
);

    localparam int ACC_W = $clog2(BURST) + 9;
    localparam int FW    = DWIDTH + PRIOR_W;
    localparam logic [ACC_W:0] CAP = (ACC_W + 1)'(BURST) << 8;
    localparam logic [ACC_W:0] ONE_TOKEN = (ACC_W + 1)'(256);

    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_next;
    logic             tokens_zero;
    logic             pop_en;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FW-1:0]    fifo_head;
    drain_state_e     state_q;
    drain_state_e     state_next;

    assign tokens_zero = (acc[ACC_W-1:8] == '0);

    // The upstream pop is gated by the reset input itself and by an enable
    // cleared in reset, so no head is consumed in or just after reset.
    assign q_deque_en = rst && pop_en && q_valid && cfg_en && !fifo_full && !tokens_zero;

    // Add the refill, take one token on a pop, then clip at the bucket cap.
    always_comb begin
        acc_sum = {1'b0, acc} + (ACC_W + 1)'(cfg_rate);
        if (q_deque_en) acc_sum = acc_sum - ONE_TOKEN;
        acc_next = (acc_sum > CAP) ? CAP[ACC_W-1:0] : acc_sum[ACC_W-1:0];
    end

    always_comb begin
        state_next = RUN;
        if (!cfg_en)          state_next = IDLE;
        else if (fifo_full)   state_next = BACKPRESSURE;
        else if (tokens_zero) state_next = THROTTLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc            <= CAP[ACC_W-1:0];
            pop_en         <= 1'b0;
            state_q        <= IDLE;
            stat_pkts      <= '0;
            stat_max_prior <= '0;
        end else begin
            acc     <= acc_next;
            pop_en  <= 1'b1;
            state_q <= state_next;
            if (q_deque_en) begin
                stat_pkts <= stat_pkts + 32'd1;
                if (q_prior > stat_max_prior) stat_max_prior <= q_prior;
            end
        end
    end

    assign state = state_q;

    // Downstream stream: a beat transfers when m_valid and m_ready are both
    // high; while m_valid is high without m_ready the head holds steady.
    pkt_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (q_deque_en),
        .wr_data ({q_prior, q_data}),
        .full    (fifo_full),
        .rd_en   (m_ready),
        .rd_data (fifo_head),
        .empty   (fifo_empty)
    );

    assign m_valid = !fifo_empty;
    assign m_data  = fifo_head[DWIDTH-1:0];
    assign m_prior = fifo_head[FW-1:DWIDTH];

endmodule
